// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiplier/divider unit.
// Optional feature macro: MULTDIV_DIV_EN (builds the restoring divider).
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    localparam int          ITER        = 32;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// Bit-serial datapath: shift-add multiplier and restoring divider on operand
// magnitudes, with the sign applied after the last iteration.
// Optional feature macro: MULTDIV_DIV_EN (without it no divider is built and
// every divide reports an exception).
module multdiv_datapath
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        load,
    input  logic        step,
    input  op_t         op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        exception
);

    logic        neg_q;
    logic [63:0] mcand_q;
    logic [63:0] product_q;
    logic [31:0] mplier_q;
    logic [63:0] signed_product;
    logic [31:0] mult_result;
    logic        mult_exc;
    logic [31:0] div_result;
    logic        div_exc;

    // Multiplier registers: load magnitudes, then add the shifted multiplicand per set multiplier bit.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            product_q <= '0;
            mplier_q  <= '0;
        end else if (load) begin
            neg_q     <= operand_a[31] ^ operand_b[31];
            mcand_q   <= {32'd0, magnitude(operand_a)};
            product_q <= '0;
            mplier_q  <= magnitude(operand_b);
        end else if (step && op == OP_MULT) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Sign fix-up of the 64-bit product; overflow when bits 63:31 are not a pure sign extension.
    always_comb begin
        signed_product = neg_q ? (~product_q + 64'd1) : product_q;
        mult_result    = signed_product[31:0];
        mult_exc       = (signed_product[63:31] != {33{signed_product[31]}});
    end

`ifdef MULTDIV_DIV_EN
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] divisor_q;
    logic        div_zero_q;
    logic        div_ovf_q;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    // Trial subtraction of the divisor from the remainder shifted left by one dividend bit.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
    end

    // Restoring divider: keep the difference when it did not borrow, shifting in a quotient bit.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else if (load) begin
            quo_q      <= magnitude(operand_a);
            rem_q      <= '0;
            divisor_q  <= magnitude(operand_b);
            div_zero_q <= (operand_b == 32'd0);
            div_ovf_q  <= (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
        end else if (step && op == OP_DIV) begin
            if (!rem_diff[32]) begin
                rem_q <= rem_diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= rem_shift[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    // Signed quotient, forced to zero for a zero divisor; the most-negative / -1 case wraps naturally.
    always_comb begin
        if (div_zero_q) begin
            div_result = '0;
        end else begin
            div_result = neg_q ? (~quo_q + 32'd1) : quo_q;
        end
        div_exc = div_zero_q | div_ovf_q;
    end
`else
    // No divider hardware: a divide always reports an exception with a zero quotient.
    always_comb begin
        div_result = '0;
        div_exc    = 1'b1;
    end
`endif

    // Select the finished result for the operation in flight.
    always_comb begin
        result    = (op == OP_MULT) ? mult_result : div_result;
        exception = (op == OP_MULT) ? mult_exc : div_exc;
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit feeding the register file write port.
// Exceptions redirect the write to the status register r30 with an error code.
// Optional feature macro: MULTDIV_DIV_EN (without it a divide completes in one
// cycle as an exception).
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [4:0]       ctrl_destReg,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [WIDTH-1:0] data_writeReg
);

    import multdiv_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    state_t           state_q;
    state_t           state_d;
    op_t              op_q;
    logic [4:0]       dest_q;
    logic [CNT_W-1:0] count_q;
    logic             load;
    logic             step;
    logic [31:0]      dp_result;
    logic             dp_exc;

    // State register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a start is only honoured in IDLE, multiply taking priority over divide.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    load = 1'b1;
`ifdef MULTDIV_DIV_EN
                    state_d = RUN;
`else
                    state_d = ctrl_MULT ? RUN : DONE;
`endif
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Iteration counter plus the operation and destination captured at start.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            count_q <= '0;
            op_q    <= OP_MULT;
            dest_q  <= '0;
        end else begin
            if (load) begin
                op_q   <= ctrl_MULT ? OP_MULT : OP_DIV;
                dest_q <= ctrl_destReg;
            end
            if (state_q == RUN) begin
                count_q <= count_q + CNT_W'(1);
            end else begin
                count_q <= '0;
            end
        end
    end

    multdiv_datapath u_datapath (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .load         (load),
        .step         (step),
        .op           (op_q),
        .operand_a    (data_operandA),
        .operand_b    (data_operandB),
        .result       (dp_result),
        .exception    (dp_exc)
    );

    // Writeback only in DONE: normal results go to the destination (r0 suppressed), errors go to r30.
    always_comb begin
        busy             = (state_q != IDLE);
        data_resultRDY   = (state_q == DONE);
        data_exception   = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (state_q == DONE) begin
            data_exception = dp_exc;
            if (dp_exc) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = RSTATUS_REG;
                data_writeReg    = (op_q == OP_MULT) ? EXC_MULT : EXC_DIV;
            end else begin
                ctrl_writeEnable = (dest_q != 5'd0);
                ctrl_writeReg    = dest_q;
                data_writeReg    = dp_result;
            end
        end
    end

endmodule
